// File: rtl/circular_buffer_reader_pkg.sv
// Shared definitions for the circular-buffer reader: FSM state encodings.
package circular_buffer_reader_pkg;

  // Single-bit FSM state encodings.
  localparam logic [0:0] StFill = 1'b0;  // accumulating words into the pack register
  localparam logic [0:0] StHold = 1'b1;  // packed word presented downstream

  // Lane-index width; at least one bit so PACK==1 still yields a legal vector.
  function automatic int unsigned idx_width(input int unsigned pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

endpackage

// File: rtl/circular_buffer_reader.sv
// Consumer-side reader: pops fall-through buffer words, packs PACK of them into one wide
// word and offers it on an out_valid/out_ready handshake. Flush emits a partial pack.
module circular_buffer_reader
  import circular_buffer_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PACK   = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   buf_valid,
  input  logic [DATA_W-1:0]      buf_data,
  output logic                   read_en,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W*PACK-1:0] out_data,
  output logic [CNT_W-1:0]       out_cnt
);

  localparam int unsigned IdxW = idx_width(PACK);

  logic [0:0]             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_W*PACK-1:0] pack_q, pack_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pop;

  // Pop request: only with a word present, and in HOLD only when the output drains.
  always_comb begin
    read_en = ~rst & buf_valid & ((state_q == StFill) | out_ready);
    pop     = read_en;
  end

  // Next-state logic for the FSM, lane index, pack register and lane count.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    cnt_d   = cnt_q;
    if (state_q == StFill) begin
      if (pop) begin
        for (int k = 0; k < int'(PACK); k++) begin
          if (idx_q == IdxW'(k)) pack_d[k*DATA_W +: DATA_W] = buf_data;
        end
        if (flush || (idx_q == IdxW'(PACK - 1))) begin
          state_d = StHold;
          cnt_d   = CNT_W'(idx_q) + CNT_W'(1);
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end else if (flush && (idx_q != '0)) begin
        state_d = StHold;
        cnt_d   = CNT_W'(idx_q);
        idx_d   = '0;
      end
    end else if (out_ready) begin
      // Transfer completes; a same-cycle pop starts the next pack in lane 0.
      state_d = StFill;
      pack_d  = '0;
      idx_d   = '0;
      if (pop) begin
        pack_d[DATA_W-1:0] = buf_data;
        if (PACK == 1) begin
          state_d = StHold;
          cnt_d   = CNT_W'(1);
        end else begin
          idx_d = IdxW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      idx_q   <= '0;
      pack_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs come straight from state.
  always_comb begin
    out_valid = (state_q == StHold);
    out_data  = pack_q;
    out_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_circular_buffer_reader.sv
// Directed self-checking bench for circular_buffer_reader (DATA_W=8, PACK=4).
module tb_circular_buffer_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        buf_valid;
  logic [7:0]  buf_data;
  logic        read_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;

  int n_cmp = 0;
  int n_err = 0;

  circular_buffer_reader #(
    .DATA_W(8),
    .PACK  (4),
    .CNT_W (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .buf_valid(buf_valid),
    .buf_data (buf_data),
    .read_en  (read_en),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_cnt  (out_cnt)
  );

  // 10 ns clock, rising edges at 5, 15, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance across one rising edge; land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic [2:0] c);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".cnt"}, {29'd0, out_cnt}, {29'd0, c});
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1; buf_valid = 1'b1; buf_data = 8'h00; flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst.read_en", {31'd0, read_en}, 32'd0);
    chk_out("rst", 1'b0, 32'h0, 3'd0);
    buf_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;

    // Four pops fill a full pack.
    buf_valid = 1'b1; buf_data = 8'h11; #1;
    chk("fill.read_en", {31'd0, read_en}, 32'd1);
    tick(); buf_data = 8'h22;
    tick(); buf_data = 8'h33;
    tick(); buf_data = 8'h44;
    tick();
    // Hold with downstream stalled while the buffer has a word.
    out_ready = 1'b0; buf_data = 8'h55; #1;
    chk_out("full", 1'b1, 32'h44332211, 3'd4);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      chk("stall.read_en", {31'd0, read_en}, 32'd0);
      tick();
      chk("stall.data", out_data, held);
    end
    chk_out("stall.end", 1'b1, 32'h44332211, 3'd4);
    out_ready = 1'b1; #1;
    chk("drain.read_en", {31'd0, read_en}, 32'd1);
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);
    chk("drain.lane0", out_data, 32'h00000055);
    buf_data = 8'h66; tick();
    buf_data = 8'h77; tick();
    buf_data = 8'h88; tick();
    buf_valid = 1'b0; #1;
    chk_out("second", 1'b1, 32'h88776655, 3'd4);
    tick();
    chk_out("cleared", 1'b0, 32'h0, 3'd4);

    // Partial pack via flush without a pop.
    buf_valid = 1'b1; buf_data = 8'hAA; tick();
    buf_data = 8'hBB; tick();
    buf_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; #1;
    chk_out("flush2", 1'b1, 32'h0000BBAA, 3'd2);
    tick();
    chk("flush2.done", {31'd0, out_valid}, 32'd0);

    // Flush together with the third pop.
    buf_valid = 1'b1; buf_data = 8'hAA; tick();
    buf_data = 8'hBB; tick();
    buf_data = 8'hCC; flush = 1'b1; tick();
    flush = 1'b0; buf_valid = 1'b0; #1;
    chk_out("flush3", 1'b1, 32'h00CCBBAA, 3'd3);
    tick();

    // Flush at idx 0 with an empty buffer does nothing.
    flush = 1'b1; #1;
    chk("flush0.read_en", {31'd0, read_en}, 32'd0);
    tick();
    chk("flush0.valid", {31'd0, out_valid}, 32'd0);
    chk("flush0.data", out_data, 32'h0);
    flush = 1'b0;
    tick();
    chk("flush0.idle", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream of eight words.
    for (int i = 1; i <= 8; i++) begin
      buf_valid = 1'b1; buf_data = 8'(i); #1;
      chk("stream.read_en", {31'd0, read_en}, 32'd1);
      tick();
      if (i == 4) chk_out("stream.a", 1'b1, 32'h04030201, 3'd4);
      if (i == 5) chk("stream.lane0", out_data, 32'h00000005);
    end
    buf_valid = 1'b0; #1;
    chk_out("stream.b", 1'b1, 32'h08070605, 3'd4);
    tick();

    // Reset mid-pack at idx 2.
    buf_valid = 1'b1; buf_data = 8'h09; tick();
    buf_data = 8'h0A; tick();
    chk("pre_rst.data", out_data, 32'h00000A09);
    #2 rst = 1'b1; #1;
    chk("mid_rst.read_en", {31'd0, read_en}, 32'd0);
    chk_out("mid_rst", 1'b0, 32'h0, 3'd0);
    buf_valid = 1'b0;
    tick();
    rst = 1'b0; #1;
    buf_valid = 1'b1; buf_data = 8'hB1; tick();
    chk("restart.lane0", out_data, 32'h000000B1);
    buf_data = 8'hB2; tick();
    buf_data = 8'hB3; tick();
    buf_data = 8'hB4; tick();
    buf_valid = 1'b0; #1;
    chk_out("restart", 1'b1, 32'hB4B3B2B1, 3'd4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
